// File: rtl/regfile16_onehot_wr.sv
// rtl/regfile16_onehot_wr.sv - 16-entry register file with one-hot write select and two registered read ports
// Optional same-edge write-to-read bypass: define REGFILE_WRITE_BYPASS_EN.
module regfile16_onehot_wr #(
   parameter int WIDTH    = 8,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      wr_sel,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [3:0]       rd_addr_a,
   input  logic [3:0]       rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             sel_err,
   input  logic             clr_err,
   output logic [7:0]       wr_count
);

   logic [WIDTH-1:0] regs [16];
   logic             multi_hot;
   logic             one_hot;
   logic             wr_en;
   logic [3:0]       wr_idx;
   logic [WIDTH-1:0] rd_next_a;
   logic [WIDTH-1:0] rd_next_b;

   // x & (x-1) is nonzero exactly when two or more bits are set
   always_comb begin
      multi_hot = |(wr_sel & (wr_sel - 16'd1));
      one_hot   = (wr_sel != 16'd0) && !multi_hot;
      wr_idx    = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (wr_sel[i]) wr_idx = 4'(i);
      end
      wr_en = one_hot && !(ZERO_REG && (wr_idx == 4'd0));
   end

   always_comb begin
      rd_next_a = regs[rd_addr_a];
      rd_next_b = regs[rd_addr_b];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_en && (wr_idx == rd_addr_a)) rd_next_a = wr_data;
      if (wr_en && (wr_idx == rd_addr_b)) rd_next_b = wr_data;
`endif
      if (ZERO_REG && (rd_addr_a == 4'd0)) rd_next_a = '0;
      if (ZERO_REG && (rd_addr_b == 4'd0)) rd_next_b = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            regs[i] <= '0;
         end
         rd_data_a <= '0;
         rd_data_b <= '0;
         sel_err   <= 1'b0;
         wr_count  <= 8'd0;
      end else begin
         if (wr_en) begin
            regs[wr_idx] <= wr_data;
            wr_count     <= wr_count + 8'd1;
         end
         // a malformed select on the same edge as a clear keeps the flag set
         if (multi_hot) begin
            sel_err <= 1'b1;
         end else if (clr_err) begin
            sel_err <= 1'b0;
         end
         rd_data_a <= rd_next_a;
         rd_data_b <= rd_next_b;
      end
   end

endmodule

// File: tb/tb_regfile16_onehot_wr.sv
// tb/tb_regfile16_onehot_wr.sv - randomized self-checking bench for regfile16_onehot_wr (ZERO_REG=0 and 1)
module tb_regfile16_onehot_wr;

   logic        clk = 1'b0;
   bit          clk_en = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] wr_sel = '0;
   logic [7:0]  wr_data = '0;
   logic [3:0]  rd_addr_a = '0;
   logic [3:0]  rd_addr_b = '0;
   logic        clr_err = 1'b0;

   logic [7:0]  rd_a0, rd_b0, cnt0, rd_a1, rd_b1, cnt1;
   logic        err0, err1;

   int total = 0;
   int bad = 0;

   logic [7:0] m0 [16];
   logic [7:0] m1 [16];
   logic [7:0] mc0, mc1, ea0, eb0, ea1, eb1;
   logic       me0, me1;

   always #5 if (clk_en) clk = ~clk;

   regfile16_onehot_wr #(.WIDTH(8), .ZERO_REG(1'b0)) dut0 (
      .clk(clk), .reset(reset), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_a0), .rd_data_b(rd_b0), .sel_err(err0),
      .clr_err(clr_err), .wr_count(cnt0));

   regfile16_onehot_wr #(.WIDTH(8), .ZERO_REG(1'b1)) dut1 (
      .clk(clk), .reset(reset), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_a1), .rd_data_b(rd_b1), .sel_err(err1),
      .clr_err(clr_err), .wr_count(cnt1));

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m0[i] = 8'h00;
         m1[i] = 8'h00;
      end
      mc0 = 0; mc1 = 0; me0 = 0; me1 = 0;
      ea0 = 0; eb0 = 0; ea1 = 0; eb1 = 0;
   endtask

   // Apply one cycle of inputs, advance the reference model at the edge, sample 1 time unit later.
   task automatic drive_cycle(input logic [15:0] s, input logic [7:0] d,
                              input logic [3:0] a, input logic [3:0] b, input logic c);
      int  pc;
      int  idx;
      bit  w0, w1;
      wr_sel = s; wr_data = d; rd_addr_a = a; rd_addr_b = b; clr_err = c;
      @(posedge clk);
      pc  = $countones(s);
      idx = 0;
      for (int i = 0; i < 16; i++) if (s[i]) idx = i;
      if (reset) begin
         model_clear();
      end else begin
         w0 = (pc == 1);
         w1 = (pc == 1) && (idx != 0);
         ea0 = m0[a]; eb0 = m0[b]; ea1 = m1[a]; eb1 = m1[b];
`ifdef REGFILE_WRITE_BYPASS_EN
         if (w0 && idx == int'(a)) ea0 = d;
         if (w0 && idx == int'(b)) eb0 = d;
         if (w1 && idx == int'(a)) ea1 = d;
         if (w1 && idx == int'(b)) eb1 = d;
`endif
         if (a == 0) ea1 = 0;
         if (b == 0) eb1 = 0;
         if (w0) begin m0[idx] = d; mc0 = mc0 + 8'd1; end
         if (w1) begin m1[idx] = d; mc1 = mc1 + 8'd1; end
         if (pc >= 2) begin me0 = 1; me1 = 1; end
         else if (c) begin me0 = 0; me1 = 0; end
      end
      #1;
   endtask

   task automatic test_reset();
      #3 reset = 1'b1;
      #2;
      total += 8;
      if (rd_a0 !== 8'h00) begin bad++; $display("FAIL reset_rd_a0 got=%h exp=00", rd_a0); end
      if (rd_b0 !== 8'h00) begin bad++; $display("FAIL reset_rd_b0 got=%h exp=00", rd_b0); end
      if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err0 got=%b exp=0", err0); end
      if (cnt0 !== 8'h00) begin bad++; $display("FAIL reset_cnt0 got=%h exp=00", cnt0); end
      if (rd_a1 !== 8'h00) begin bad++; $display("FAIL reset_rd_a1 got=%h exp=00", rd_a1); end
      if (rd_b1 !== 8'h00) begin bad++; $display("FAIL reset_rd_b1 got=%h exp=00", rd_b1); end
      if (err1 !== 1'b0) begin bad++; $display("FAIL reset_err1 got=%b exp=0", err1); end
      if (cnt1 !== 8'h00) begin bad++; $display("FAIL reset_cnt1 got=%h exp=00", cnt1); end
      model_clear();
      clk_en = 1'b1;
      drive_cycle(16'h0, 8'h0, 4'd0, 4'd0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 16; i++)
         drive_cycle(16'(1 << i), 8'(8'h10 + i), 4'd0, 4'd0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         drive_cycle(16'h0, 8'h0, 4'(i), 4'(15 - i), 1'b0);
         total += 4;
         if (rd_a0 !== 8'(8'h10 + i)) begin bad++; $display("FAIL sweep_a0[%0d] got=%h exp=%h", i, rd_a0, 8'(8'h10 + i)); end
         if (rd_b0 !== eb0) begin bad++; $display("FAIL sweep_b0[%0d] got=%h exp=%h", i, rd_b0, eb0); end
         if (rd_a1 !== ea1) begin bad++; $display("FAIL sweep_a1[%0d] got=%h exp=%h", i, rd_a1, ea1); end
         if (rd_b1 !== eb1) begin bad++; $display("FAIL sweep_b1[%0d] got=%h exp=%h", i, rd_b1, eb1); end
      end
      total += 2;
      if (cnt0 !== 8'd16) begin bad++; $display("FAIL sweep_cnt0 got=%0d exp=16", cnt0); end
      if (cnt1 !== 8'd15) begin bad++; $display("FAIL sweep_cnt1 got=%0d exp=15", cnt1); end
   endtask

   task automatic test_illegal();
      logic [7:0] c0;
      drive_cycle(16'h0008, 8'hAA, 4'd0, 4'd0, 1'b0);
      c0 = cnt0;
      drive_cycle(16'h0009, 8'h55, 4'd3, 4'd0, 1'b0);
      total += 3;
      if (err0 !== 1'b1) begin bad++; $display("FAIL illegal_err0 got=%b exp=1", err0); end
      if (err1 !== 1'b1) begin bad++; $display("FAIL illegal_err1 got=%b exp=1", err1); end
      if (cnt0 !== c0) begin bad++; $display("FAIL illegal_cnt0 got=%h exp=%h", cnt0, c0); end
      drive_cycle(16'h0, 8'h0, 4'd3, 4'd0, 1'b1);
      total += 3;
      if (rd_a0 !== 8'hAA) begin bad++; $display("FAIL illegal_reg3 got=%h exp=aa", rd_a0); end
      if (rd_b0 !== 8'h10) begin bad++; $display("FAIL illegal_reg0 got=%h exp=10", rd_b0); end
      if (err0 !== 1'b0) begin bad++; $display("FAIL clr_err0 got=%b exp=0", err0); end
      drive_cycle(16'h0003, 8'h66, 4'd0, 4'd1, 1'b1);
      total += 3;
      if (err0 !== 1'b1) begin bad++; $display("FAIL setwins_err0 got=%b exp=1", err0); end
      if (err1 !== me1) begin bad++; $display("FAIL setwins_err1 got=%b exp=%b", err1, me1); end
      if (cnt0 !== c0) begin bad++; $display("FAIL setwins_cnt0 got=%h exp=%h", cnt0, c0); end
      drive_cycle(16'h0, 8'h0, 4'd0, 4'd1, 1'b1);
      total += 2;
      if (rd_b0 !== 8'h11) begin bad++; $display("FAIL setwins_reg1 got=%h exp=11", rd_b0); end
      if (err0 !== 1'b0) begin bad++; $display("FAIL clr2_err0 got=%b exp=0", err0); end
   endtask

   task automatic test_rdw();
      logic [7:0] exp_same;
`ifdef REGFILE_WRITE_BYPASS_EN
      exp_same = 8'h22;
`else
      exp_same = 8'h11;
`endif
      drive_cycle(16'h0020, 8'h11, 4'd0, 4'd0, 1'b0);
      drive_cycle(16'h0020, 8'h22, 4'd5, 4'd5, 1'b0);
      total += 3;
      if (rd_a0 !== exp_same) begin bad++; $display("FAIL rdw_same_a0 got=%h exp=%h", rd_a0, exp_same); end
      if (rd_b1 !== exp_same) begin bad++; $display("FAIL rdw_same_b1 got=%h exp=%h", rd_b1, exp_same); end
      if (rd_a1 !== ea1) begin bad++; $display("FAIL rdw_same_a1 got=%h exp=%h", rd_a1, ea1); end
      drive_cycle(16'h0, 8'h0, 4'd5, 4'd5, 1'b0);
      total += 2;
      if (rd_a0 !== 8'h22) begin bad++; $display("FAIL rdw_next_a0 got=%h exp=22", rd_a0); end
      if (rd_b1 !== 8'h22) begin bad++; $display("FAIL rdw_next_b1 got=%h exp=22", rd_b1); end
   endtask

   task automatic test_zero_wrap();
      reset = 1'b1;
      drive_cycle(16'h0, 8'h0, 4'd0, 4'd0, 1'b0);
      reset = 1'b0;
      drive_cycle(16'h0001, 8'hFF, 4'd0, 4'd0, 1'b0);
      drive_cycle(16'h0, 8'h0, 4'd0, 4'd0, 1'b0);
      total += 4;
      if (rd_a1 !== 8'h00) begin bad++; $display("FAIL zero_rd_a1 got=%h exp=00", rd_a1); end
      if (cnt1 !== 8'h00) begin bad++; $display("FAIL zero_cnt1 got=%h exp=00", cnt1); end
      if (rd_a0 !== 8'hFF) begin bad++; $display("FAIL zero_rd_a0 got=%h exp=ff", rd_a0); end
      if (cnt0 !== 8'h01) begin bad++; $display("FAIL zero_cnt0 got=%h exp=01", cnt0); end
      for (int i = 0; i < 256; i++)
         drive_cycle(16'h0002, 8'(i), 4'd0, 4'd1, 1'b0);
      total += 3;
      if (cnt1 !== 8'h00) begin bad++; $display("FAIL wrap_cnt1 got=%h exp=00", cnt1); end
      if (cnt0 !== 8'h01) begin bad++; $display("FAIL wrap_cnt0 got=%h exp=01", cnt0); end
      if (rd_a1 !== 8'h00) begin bad++; $display("FAIL wrap_rd_a1 got=%h exp=00", rd_a1); end
   endtask

   task automatic test_random();
      logic [15:0] s;
      int          r;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 3);
         if (r == 0) s = 16'h0;
         else if (r < 3) s = 16'(1 << $urandom_range(0, 15));
         else begin
            s = 16'($urandom);
            if ($countones(s) < 2) s = 16'h8001;
         end
         drive_cycle(s, 8'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
         total += 8;
         if (rd_a0 !== ea0) begin bad++; $display("FAIL rnd_a0[%0d] got=%h exp=%h", n, rd_a0, ea0); end
         if (rd_b0 !== eb0) begin bad++; $display("FAIL rnd_b0[%0d] got=%h exp=%h", n, rd_b0, eb0); end
         if (rd_a1 !== ea1) begin bad++; $display("FAIL rnd_a1[%0d] got=%h exp=%h", n, rd_a1, ea1); end
         if (rd_b1 !== eb1) begin bad++; $display("FAIL rnd_b1[%0d] got=%h exp=%h", n, rd_b1, eb1); end
         if (err0 !== me0) begin bad++; $display("FAIL rnd_err0[%0d] got=%b exp=%b", n, err0, me0); end
         if (err1 !== me1) begin bad++; $display("FAIL rnd_err1[%0d] got=%b exp=%b", n, err1, me1); end
         if (cnt0 !== mc0) begin bad++; $display("FAIL rnd_cnt0[%0d] got=%h exp=%h", n, cnt0, mc0); end
         if (cnt1 !== mc1) begin bad++; $display("FAIL rnd_cnt1[%0d] got=%h exp=%h", n, cnt1, mc1); end
      end
   endtask

   task automatic test_reset_mid();
      drive_cycle(16'h0004, 8'h5A, 4'd0, 4'd0, 1'b0);
      drive_cycle(16'h0, 8'h0, 4'd2, 4'd2, 1'b0);
      total += 1;
      if (rd_a0 !== 8'h5A) begin bad++; $display("FAIL mid_pre_a0 got=%h exp=5a", rd_a0); end
      reset = 1'b1;
      #1;
      total += 2;
      if (rd_a0 !== 8'h00) begin bad++; $display("FAIL mid_async_a0 got=%h exp=00", rd_a0); end
      if (cnt0 !== 8'h00) begin bad++; $display("FAIL mid_async_cnt0 got=%h exp=00", cnt0); end
      drive_cycle(16'h0080, 8'h77, 4'd7, 4'd7, 1'b0);
      reset = 1'b0;
      drive_cycle(16'h0, 8'h0, 4'd7, 4'd2, 1'b0);
      total += 3;
      if (rd_a0 !== 8'h00) begin bad++; $display("FAIL mid_lost_a0 got=%h exp=00", rd_a0); end
      if (rd_b0 !== 8'h00) begin bad++; $display("FAIL mid_lost_b0 got=%h exp=00", rd_b0); end
      if (cnt0 !== 8'h00) begin bad++; $display("FAIL mid_lost_cnt0 got=%h exp=00", cnt0); end
      drive_cycle(16'h0080, 8'h77, 4'd0, 4'd0, 1'b0);
      drive_cycle(16'h0, 8'h0, 4'd7, 4'd7, 1'b0);
      total += 3;
      if (rd_a0 !== 8'h77) begin bad++; $display("FAIL mid_after_a0 got=%h exp=77", rd_a0); end
      if (rd_b1 !== 8'h77) begin bad++; $display("FAIL mid_after_b1 got=%h exp=77", rd_b1); end
      if (cnt0 !== 8'h01) begin bad++; $display("FAIL mid_after_cnt0 got=%h exp=01", cnt0); end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_illegal();
      test_rdw();
      test_zero_wrap();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile16_onehot_wr.md
Name: regfile16_onehot_wr

Overview:
- 16-entry register file that consumes the one-hot write-select vector from the 4-to-16 write-address decoder, whose load input gates that vector.
- Sits directly downstream of the decoder in the datapath.
- One write port driven by the one-hot select; two registered read ports addressed by 4-bit binary indices.
- Checks the select vector for legality and flags malformed selects.

Parameters:
- WIDTH, 8, data width of each register and of the read/write data buses.
- ZERO_REG, 0, when 1, register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- wr_sel  input  16  one-hot write select from the decoder; all-zero means no write.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  4  read port A address.
- rd_addr_b  input  4  read port B address.
- rd_data_a  output  WIDTH  registered read data, port A.
- rd_data_b  output  WIDTH  registered read data, port B.
- sel_err  output  1  sticky flag: a multi-hot wr_sel was seen.
- clr_err  input  1  synchronous clear of sel_err.
- wr_count  output  8  count of accepted writes, wraps modulo 256.

Behaviour:
- Reset (asynchronous, active-high):
  - all 16 registers, rd_data_a, rd_data_b, sel_err and wr_count go to 0 immediately.
  - Held while reset=1, regardless of clk.
- Select classification each cycle: popcount(wr_sel).
  - 0: idle, no write.
  - 1: legal write.
  - 2 or more: illegal.
- Legal write: on the rising edge, reg[i] <= wr_data where wr_sel[i]=1.
  - wr_count increments by 1.
  - Exception: ZERO_REG=1 and i=0 discards the write and does not increment wr_count.
- Illegal select:
  - No register is modified and wr_count is unchanged.
  - sel_err <= 1 on that edge.
- sel_err priority:
  - If clr_err=1 and an illegal select occur on the same edge, sel_err ends at 1 (set wins).
  - clr_err alone clears sel_err to 0 on the next edge.
- Reads:
  - On each rising edge, rd_data_a <= reg[rd_addr_a] and rd_data_b <= reg[rd_addr_b].
  - Latency is 1 cycle from address to data.
  - Both ports may address the same register.
- Read-during-write to the same index on the same edge, with WRITE_BYPASS_EN undefined: the read returns the pre-write (old) contents. See Optional Feature.
- ZERO_REG=1: the read mux forces 0 for address 0 on both ports, including under bypass.
- wr_count wraps from 255 to 0 with no flag.
- Reset asserted mid-write: the write is lost and all state is 0; the first legal edge after deassertion writes normally.
- No X propagation: with wr_sel all-zero, register contents are held indefinitely.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - A legal write to reg[i] on the same edge that a read port addresses i loads that port's rd_data with wr_data (new data).
  - Each port bypasses independently.
  - No bypass occurs on illegal selects.
  - With ZERO_REG=1, index 0 still reads 0.
- Undefined:
  - Same-edge read returns the old contents.
  - The new value is visible one cycle later.
- Register contents and wr_count are identical in both builds.

Test Plan:
- Reset then idle: assert reset with clk stopped -> rd_data_a=rd_data_b=0, sel_err=0, wr_count=0 with no clock edge required.
- Full sweep:
  - Write reg[i]=i+8'h10 for i=0..15 with one-hot wr_sel, then read all pairs (i, 15-i).
  - Expected (ZERO_REG=0): rd_data_a=8'h10+i one cycle after its address; wr_count=16.
- Illegal select:
  - Write reg[3]=8'hAA, then apply wr_sel=16'h0009 with wr_data=8'h55.
  - Expected: reg[0] and reg[3] unchanged (reg[3]=8'hAA), sel_err=1, wr_count unchanged.
  - Then clr_err=1 for one cycle -> sel_err=0.
  - Then clr_err=1 together with wr_sel=16'h0003 -> sel_err stays 1.
- Read-during-write:
  - reg[5]=8'h11; apply wr_sel=16'h0020, wr_data=8'h22, rd_addr_a=5.
  - Expected: rd_data_a=8'h11 without REGFILE_WRITE_BYPASS_EN, 8'h22 with it; the next cycle reads 8'h22 in both builds.
- ZERO_REG=1 and wrap:
  - Write 8'hFF via wr_sel=16'h0001 -> rd_data at address 0 is 0 and wr_count does not increment.
  - Then perform 256 legal writes to reg[1] -> wr_count returns to 0.
- Reset mid-operation: assert reset coincident with a legal write to reg[7]=8'h77 -> reg[7]=0 after reset, and a following legal write lands normally.
